// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one strobe-protocol memory between two req/ack ports.
// One transaction in flight; single-cycle mem_wr/mem_rd strobes; read waits RD_LAT edges.
module mem_arbiter #(
    parameter int unsigned AW     = 4,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_w,
    output logic          mem_wr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_data_r,
    output logic [1:0]    dbg_state,
    output logic          dbg_owner
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state;
    logic       owner;
    logic       we_q;
    logic       last_grant;
    logic [2:0] cnt;
    logic       grant;

    // On a tie the port that did not win last time goes next.
    always_comb begin
        grant = m1_req;
        if (m0_req && m1_req)
            grant = ~last_grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            we_q        <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            mem_address <= '0;
            mem_data_w  <= '0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner       <= grant;
                        last_grant  <= grant;
                        we_q        <= grant ? m1_we    : m0_we;
                        mem_address <= grant ? m1_addr  : m0_addr;
                        mem_data_w  <= grant ? m1_wdata : m0_wdata;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_wr <= we_q;
                    mem_rd <= ~we_q;
                    cnt    <= 3'(RD_LAT - 1);
                    state  <= WAIT;
                end
                WAIT: begin
                    mem_wr <= 1'b0;
                    mem_rd <= 1'b0;
                    if (we_q || cnt == '0) begin
                        if (owner) begin
                            m1_ack <= 1'b1;
                            if (!we_q) m1_rdata <= mem_data_r;
                        end else begin
                            m0_ack <= 1'b1;
                            if (!we_q) m0_rdata <= mem_data_r;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;
    assign dbg_owner = owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memories with registered read data,
// scoreboard of expected completions popped when an ack is observed.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [3:0] m0_addr = '0, m1_addr = '0;
    logic [7:0] m0_wdata = '0, m1_wdata = '0;
    logic       m0_ack, m1_ack, mem_wr, mem_rd, dbg_owner;
    logic [7:0] m0_rdata, m1_rdata, mem_data_w, mem_data_r;
    logic [3:0] mem_address;
    logic [1:0] dbg_state;

    // second instance built with RD_LAT=3; only its port 0 is exercised
    logic       c_req = 0, c_we = 0;
    logic [3:0] c_addr = '0;
    logic [7:0] c_wdata = '0;
    logic       c_ack, z_ack, c_mem_wr, c_mem_rd, c_owner;
    logic [7:0] c_rdata, z_rdata, c_mem_data_w, c_mem_data_r;
    logic [3:0] c_mem_address;
    logic [1:0] c_state;

    typedef struct packed {
        logic       port;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       got;
    logic [7:0] mdl[16];
    logic [7:0] mem[16];
    logic [7:0] mem3[16];
    logic [7:0] rd_q1, rd3_q1, rd3_q2;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(4), .DW(8), .RD_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_data_w(mem_data_w), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_data_r(mem_data_r), .dbg_state(dbg_state), .dbg_owner(dbg_owner)
    );

    mem_arbiter #(.AW(4), .DW(8), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .m0_req(c_req), .m0_we(c_we), .m0_addr(c_addr), .m0_wdata(c_wdata),
        .m0_ack(c_ack), .m0_rdata(c_rdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(4'h0), .m1_wdata(8'h00),
        .m1_ack(z_ack), .m1_rdata(z_rdata),
        .mem_address(c_mem_address), .mem_data_w(c_mem_data_w), .mem_wr(c_mem_wr), .mem_rd(c_mem_rd),
        .mem_data_r(c_mem_data_r), .dbg_state(c_state), .dbg_owner(c_owner)
    );

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        if (i == 5)  return 8'hA7;
        if (i == 15) return 8'h81;
        v = 8'(i * 17);
        return v ^ 8'h5A;
    endfunction

    // Memory with one registered read stage (RD_LAT=2 instance) and two stages (RD_LAT=3)
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem[i]  <= init_val(i);
                mem3[i] <= init_val(i);
            end
            rd_q1  <= '0;
            rd3_q1 <= '0;
            rd3_q2 <= '0;
        end else begin
            if (mem_wr)   mem[mem_address]    <= mem_data_w;
            if (mem_rd)   rd_q1               <= mem[mem_address];
            if (c_mem_wr) mem3[c_mem_address] <= c_mem_data_w;
            if (c_mem_rd) rd3_q1              <= mem3[c_mem_address];
            rd3_q2 <= rd3_q1;
        end
    end
    assign mem_data_r   = rd_q1;
    assign c_mem_data_r = rd3_q2;

    // Single-port transaction on the RD_LAT=2 instance; edge 0 is the grant edge.
    task automatic do_txn(input logic port, input logic we, input logic [3:0] addr,
                          input logic [3:0] addr_late, input logic [7:0] wdata,
                          output int ack_edge, output int rd_cnt, output int wr_cnt,
                          output int strobe_edge, output logic [3:0] s_addr, output logic [7:0] s_data,
                          output logic other_ack, output logic both, output logic [1:0] grant_state,
                          output logic grant_owner, output logic [1:0] ack_state);
        ack_edge = -1; rd_cnt = 0; wr_cnt = 0; strobe_edge = -1; s_addr = '0; s_data = '0;
        other_ack = 0; both = 0; grant_state = '0; grant_owner = 0; ack_state = '0;
        if (port) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else      begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                grant_state = dbg_state;
                grant_owner = dbg_owner;
                if (port) begin m1_addr = addr_late; m1_wdata = ~wdata; m1_we = ~we; end
                else      begin m0_addr = addr_late; m0_wdata = ~wdata; m0_we = ~we; end
            end
            if (mem_rd || mem_wr) begin
                if (strobe_edge < 0) strobe_edge = e;
                s_addr = mem_address;
                s_data = mem_data_w;
            end
            if (mem_rd) rd_cnt++;
            if (mem_wr) wr_cnt++;
            if (mem_rd && mem_wr) both = 1;
            if (port ? m0_ack : m1_ack) other_ack = 1;
            if (port ? m1_ack : m0_ack) begin
                ack_edge  = e;
                ack_state = dbg_state;
                break;
            end
        end
        m0_req = 0;
        m1_req = 0;
    endtask

    task automatic test_reset();
        logic seen;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        n_checks++; if ({mem_wr, mem_rd, m0_ack, m1_ack, dbg_owner} !== 5'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b expected 00000", {mem_wr, mem_rd, m0_ack, m1_ack, dbg_owner}); end
        n_checks++; if ({mem_address, mem_data_w, m0_rdata, m1_rdata} !== 28'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", {mem_address, mem_data_w, m0_rdata, m1_rdata}); end
        reset = 0;
        m0_req = 1; m0_we = 0; m0_addr = 4'h2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (mem_rd !== 1'b1 || mem_address !== 4'h2) begin n_fail++; $display("FAIL rst_pre_rd: got rd=%b addr=%h expected rd=1 addr=2", mem_rd, mem_address); end
        @(posedge clk); #1;
        n_checks++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL rst_pre_wait: got %0d expected 2", dbg_state); end
        m0_req = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected 0", dbg_state); end
        n_checks++; if ({mem_wr, mem_rd, m0_ack, m1_ack} !== 4'b0 || mem_address !== 4'h0) begin n_fail++; $display("FAIL rst_mid_out: got %b addr=%h expected 0000 addr=0", {mem_wr, mem_rd, m0_ack, m1_ack}, mem_address); end
        reset = 0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack || mem_rd || mem_wr || dbg_state != 2'd0) seen = 1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_ack: got activity=%b expected 0", seen); end
    endtask

    task automatic test_m0_read();
        int ae, rc, wc, se; logic [3:0] sa; logic [7:0] sd; logic oa, bo, go; logic [1:0] gs, as;
        sb.push_back('{port: 1'b0, rd: 1'b1, data: mdl[5]});
        do_txn(1'b0, 1'b0, 4'h5, 4'h5, 8'h00, ae, rc, wc, se, sa, sd, oa, bo, gs, go, as);
        n_checks++; if (gs !== 2'd1 || go !== 1'b0) begin n_fail++; $display("FAIL t2_grant: got state=%0d owner=%b expected 1/0", gs, go); end
        n_checks++; if (ae !== 3) begin n_fail++; $display("FAIL t2_ack_edge: got %0d expected 3", ae); end
        n_checks++; if (rc !== 1 || wc !== 0 || se !== 1 || sa !== 4'h5) begin n_fail++; $display("FAIL t2_strobe: got rd=%0d wr=%0d at=%0d addr=%h expected 1/0/1/5", rc, wc, se, sa); end
        n_checks++; if (as !== 2'd3 || oa !== 1'b0) begin n_fail++; $display("FAIL t2_done: got state=%0d other_ack=%b expected 3/0", as, oa); end
        got = sb.pop_front();
        n_checks++; if (m0_rdata !== got.data) begin n_fail++; $display("FAIL t2_rdata: got %h expected %h", m0_rdata, got.data); end
        @(posedge clk); #1;
        n_checks++; if (m0_ack !== 1'b0 || dbg_state !== 2'd0 || m0_rdata !== got.data) begin n_fail++; $display("FAIL t2_after: got ack=%b state=%0d rdata=%h expected 0/0/%h", m0_ack, dbg_state, m0_rdata, got.data); end
        n_checks++; if (m1_rdata !== 8'h00) begin n_fail++; $display("FAIL t2_other_rdata: got %h expected 00", m1_rdata); end
    endtask

    task automatic test_m1_write();
        int ae, rc, wc, se; logic [3:0] sa; logic [7:0] sd; logic oa, bo, go; logic [1:0] gs, as;
        logic [7:0] r0, r1;
        r0 = m0_rdata; r1 = m1_rdata;
        sb.push_back('{port: 1'b1, rd: 1'b0, data: 8'h3C});
        do_txn(1'b1, 1'b1, 4'h3, 4'h3, 8'h3C, ae, rc, wc, se, sa, sd, oa, bo, gs, go, as);
        mdl[3] = 8'h3C;
        got = sb.pop_front();
        n_checks++; if (go !== got.port) begin n_fail++; $display("FAIL t3_owner: got %b expected %b", go, got.port); end
        n_checks++; if (ae !== 2) begin n_fail++; $display("FAIL t3_ack_edge: got %0d expected 2", ae); end
        n_checks++; if (wc !== 1 || rc !== 0 || se !== 1) begin n_fail++; $display("FAIL t3_strobe: got wr=%0d rd=%0d at=%0d expected 1/0/1", wc, rc, se); end
        n_checks++; if (sa !== 4'h3 || sd !== got.data) begin n_fail++; $display("FAIL t3_wdata: got addr=%h data=%h expected 3/%h", sa, sd, got.data); end
        n_checks++; if (oa !== 1'b0 || bo !== 1'b0) begin n_fail++; $display("FAIL t3_m0_ack: got other_ack=%b both=%b expected 0/0", oa, bo); end
        n_checks++; if (m0_rdata !== r0 || m1_rdata !== r1) begin n_fail++; $display("FAIL t3_rdata_kept: got %h/%h expected %h/%h", m0_rdata, m1_rdata, r0, r1); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int acks, last_ack, bad_both;
        acks = 0; last_ack = 0; bad_both = 0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{port: 1'b0, rd: 1'b1, data: mdl[7]});
            sb.push_back('{port: 1'b1, rd: 1'b1, data: mdl[3]});
        end
        m0_we = 0; m0_addr = 4'h7; m1_we = 0; m1_addr = 4'h3;
        m0_req = 1; m1_req = 1;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (mem_rd && mem_wr) bad_both++;
            if (m0_ack || m1_ack) begin
                got = sb.pop_front();
                n_checks++; if (m1_ack !== got.port || (m0_ack && m1_ack)) begin n_fail++; $display("FAIL t4_order%0d: got m0_ack=%b m1_ack=%b expected port %b", acks, m0_ack, m1_ack, got.port); end
                n_checks++; if ((got.port ? m1_rdata : m0_rdata) !== got.data) begin n_fail++; $display("FAIL t4_rdata%0d: got %h expected %h", acks, got.port ? m1_rdata : m0_rdata, got.data); end
                n_checks++; if (dbg_owner !== got.port) begin n_fail++; $display("FAIL t4_owner%0d: got %b expected %b", acks, dbg_owner, got.port); end
                if (acks > 0) begin
                    n_checks++; if (e - last_ack !== 5) begin n_fail++; $display("FAIL t4_spacing%0d: got %0d expected 5", acks, e - last_ack); end
                end
                last_ack = e;
                acks++;
                if (acks == 4) begin m0_req = 0; m1_req = 0; break; end
            end
        end
        m0_req = 0; m1_req = 0;
        sb.delete();
        n_checks++; if (acks !== 4 || bad_both !== 0) begin n_fail++; $display("FAIL t4_count: got acks=%0d both=%0d expected 4/0", acks, bad_both); end
        @(posedge clk); #1;
    endtask

    task automatic test_addr_hold();
        int ae, rc, wc, se; logic [3:0] sa; logic [7:0] sd; logic oa, bo, go; logic [1:0] gs, as;
        sb.push_back('{port: 1'b0, rd: 1'b1, data: mdl[5]});
        do_txn(1'b0, 1'b0, 4'h5, 4'h9, 8'h00, ae, rc, wc, se, sa, sd, oa, bo, gs, go, as);
        got = sb.pop_front();
        n_checks++; if (sa !== 4'h5 || rc !== 1 || wc !== 0) begin n_fail++; $display("FAIL t5_addr: got addr=%h rd=%0d wr=%0d expected 5/1/0", sa, rc, wc); end
        n_checks++; if (ae !== 3 || m0_rdata !== got.data) begin n_fail++; $display("FAIL t5_rdata: got edge=%0d data=%h expected 3/%h", ae, m0_rdata, got.data); end
        @(posedge clk); #1;
        n_checks++; if (mem_address !== 4'h5) begin n_fail++; $display("FAIL t5_addr_idle: got %h expected 5", mem_address); end
    endtask

    task automatic test_rd_lat3();
        int ae, rc;
        logic [1:0] gs;
        ae = -1; rc = 0; gs = '0;
        sb.push_back('{port: 1'b0, rd: 1'b1, data: init_val(15)});
        c_req = 1; c_we = 0; c_addr = 4'hF;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin gs = c_state; c_addr = 4'h0; end
            if (c_mem_rd) rc++;
            if (c_ack) begin ae = e; break; end
        end
        c_req = 0;
        got = sb.pop_front();
        n_checks++; if (gs !== 2'd1) begin n_fail++; $display("FAIL t6_grant: got %0d expected 1", gs); end
        n_checks++; if (ae !== 4) begin n_fail++; $display("FAIL t6_ack_edge: got %0d expected 4", ae); end
        n_checks++; if (rc !== 1) begin n_fail++; $display("FAIL t6_rd_width: got %0d expected 1", rc); end
        n_checks++; if (c_rdata !== got.data) begin n_fail++; $display("FAIL t6_rdata: got %h expected %h", c_rdata, got.data); end
        n_checks++; if (z_ack !== 1'b0 || z_rdata !== 8'h00 || c_owner !== 1'b0) begin n_fail++; $display("FAIL t6_port1: got ack=%b rdata=%h owner=%b expected 0/00/0", z_ack, z_rdata, c_owner); end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = init_val(i);
        test_reset();
        test_m0_read();
        test_m1_write();
        test_round_robin();
        test_addr_hold();
        test_rd_lat3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
